// File: rtl/serial_checking_sink.sv
// serial_checking_sink
//   Terminates a router's local serial tx port. It deserialises frames made of
//   one start bit (1) followed by FLIT_W data bits sent LSB first. Each flit is
//   checked against this node's address and counted. After a flit, a
//   hospitality LFSR gates how soon the sink accepts the next frame.
//
//   Optional feature: define SINK_SEQ_CHECK_EN to add per-source sequence
//   checking. The sink keeps a table of the next expected seq for each src.
//   Without the macro the tables do not exist and only the destination is
//   checked.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   busy       : 1 = not ready for a new frame (flow control to tx)
//   data       : serial input, idles at 0
//   flit_valid : one-cycle pulse when a flit has been received
//   flit       : last received flit, held until the next one
//   rx_count   : saturating count of received flits
//   err_count  : saturating count of flits in error
//   err        : pulse with flit_valid when the flit is in error
//
// Flit layout: dest = [ADDR_SZ-1:0], src = [2*ADDR_SZ-1:ADDR_SZ],
//              seq = [FLIT_W-1:2*ADDR_SZ]
//
// state | meaning
// IDLE  | ready, waiting for a start bit
// SHIFT | sampling FLIT_W data bits, LSB first
// CHECK | flit_valid/err pulse, counters show the new values
// HOLD  | busy until the LFSR value is <= HOSP
module serial_checking_sink #(
    parameter int unsigned ID      = 0,
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned ADDR_SZ = 4,
    parameter int unsigned HOSP    = 255
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    input  logic              data,
    output logic              flit_valid,
    output logic [FLIT_W-1:0] flit,
    output logic [15:0]       rx_count,
    output logic [15:0]       err_count,
    output logic              err
);

    localparam int unsigned       CNT_W     = $clog2(FLIT_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FLIT_W - 1);
    localparam logic [7:0]        LFSR_SEED = {ID[6:0], 1'b1};
    localparam logic [ADDR_SZ-1:0] MY_ADDR  = ID[ADDR_SZ-1:0];

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [FLIT_W-1:0] shift_q, shift_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              busy_q, flit_valid_q, err_q;
    logic [FLIT_W-1:0] flit_q;
    logic [15:0]       rx_count_q, rx_count_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              dest_err, frame_err, hosp_ok;

`ifdef SINK_SEQ_CHECK_EN
    localparam int unsigned SEQ_W = FLIT_W - 2*ADDR_SZ;
    localparam int unsigned N_SRC = 2**ADDR_SZ;

    logic [N_SRC-1:0] seq_valid_q;
    logic [SEQ_W-1:0] seq_exp_q [N_SRC];
    logic [ADDR_SZ-1:0] src;
    logic [SEQ_W-1:0]   seq;
    logic               seq_err;
`endif

    always_comb begin
        // shift_d is the word including the bit sampled this cycle, so the
        // final SHIFT cycle can register the complete flit directly.
        shift_d            = shift_q;
        shift_d[bit_cnt_q] = data;
        dest_err           = (shift_d[ADDR_SZ-1:0] != MY_ADDR);
`ifdef SINK_SEQ_CHECK_EN
        src       = shift_d[2*ADDR_SZ-1:ADDR_SZ];
        seq       = shift_d[FLIT_W-1:2*ADDR_SZ];
        seq_err   = seq_valid_q[src] && (seq != seq_exp_q[src]);
        frame_err = dest_err | seq_err;
`else
        frame_err = dest_err;
`endif
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // widened compare keeps HOSP=255 from being a degenerate 8-bit compare
        hosp_ok     = ({1'b0, lfsr_q} <= 9'(HOSP));
        rx_count_d  = (rx_count_q  == 16'hFFFF) ? rx_count_q  : rx_count_q  + 16'd1;
        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            busy_q       <= 1'b0;
            flit_valid_q <= 1'b0;
            err_q        <= 1'b0;
            flit_q       <= '0;
            rx_count_q   <= '0;
            err_count_q  <= '0;
`ifdef SINK_SEQ_CHECK_EN
            seq_valid_q  <= '0;
`endif
        end else begin
            lfsr_q       <= lfsr_d;
            flit_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q      <= CHECK;
                        flit_q       <= shift_d;
                        flit_valid_q <= 1'b1;
                        err_q        <= frame_err;
                        rx_count_q   <= rx_count_d;
                        if (frame_err) begin
                            err_count_q <= err_count_d;
                        end
`ifdef SINK_SEQ_CHECK_EN
                        // always resynchronise to the seq just seen
                        seq_valid_q[src] <= 1'b1;
                        seq_exp_q[src]   <= seq + 1'b1;
`endif
                    end
                end
                CHECK: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (hosp_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign flit_valid = flit_valid_q;
    assign flit       = flit_q;
    assign rx_count   = rx_count_q;
    assign err_count  = err_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_serial_checking_sink.sv
module tb_serial_checking_sink;

    localparam int ID = 5;

    logic        clk = 1'b0;
    logic        reset, data, busy, flit_valid, err;
    logic [15:0] flit, rx_count, err_count;
    logic        reset2, data2, busy2, flit_valid2, err2;
    logic [15:0] flit2, rx_count2, err_count2;

    serial_checking_sink #(.ID(ID), .FLIT_W(16), .ADDR_SZ(4), .HOSP(255)) dut (
        .clk(clk), .reset(reset), .busy(busy), .data(data),
        .flit_valid(flit_valid), .flit(flit), .rx_count(rx_count),
        .err_count(err_count), .err(err));

    serial_checking_sink #(.ID(ID), .FLIT_W(16), .ADDR_SZ(4), .HOSP(0)) dut_h0 (
        .clk(clk), .reset(reset2), .busy(busy2), .data(data2),
        .flit_valid(flit_valid2), .flit(flit2), .rx_count(rx_count2),
        .err_count(err_count2), .err(err2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] flit;
        logic        err;
        logic [15:0] rx;
        logic [15:0] ec;
        int          vcyc;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    int  m_rx, m_ec;
    bit  m_seen[16];
    int  m_next[16];
    logic [7:0] tx_seq[16];
    int  h0_pulses = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rx = 0;
        m_ec = 0;
        for (int i = 0; i < 16; i++) begin
            m_seen[i] = 1'b0;
            m_next[i] = 0;
        end
    endtask

    function automatic exp_t predict(logic [15:0] f, int start);
        exp_t e;
        bit   bad;
        bad = (f[3:0] != 4'(ID));
`ifdef SINK_SEQ_CHECK_EN
        begin
            int src, seq;
            src = int'(f[7:4]);
            seq = int'(f[15:8]);
            if (m_seen[src] && seq != m_next[src]) bad = 1'b1;
            m_seen[src] = 1'b1;
            m_next[src] = (seq + 1) % 256;
        end
`endif
        if (m_rx < 65535) m_rx++;
        if (bad && m_ec < 65535) m_ec++;
        e.flit = f;
        e.err  = bad;
        e.rx   = 16'(m_rx);
        e.ec   = 16'(m_ec);
        e.vcyc = start + 17;
        return e;
    endfunction

    // monitor: pops one expectation per flit_valid pulse
    always @(negedge clk) begin
        if (flit_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_flit_valid", 32'(flit_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("flit", 32'(flit), 32'(e.flit));
                chk("err", 32'(err), 32'(e.err));
                chk("rx_count", 32'(rx_count), 32'(e.rx));
                chk("err_count", 32'(err_count), 32'(e.ec));
                chk("valid_cycle", 32'(cyc), 32'(e.vcyc));
            end
        end else if (err === 1'b1) begin
            chk("err_without_valid", 32'(err), 32'd0);
        end
    end

    always @(negedge clk) if (flit_valid2 === 1'b1) h0_pulses++;

    // waits (bounded) for busy low; call only at a negedge
    task automatic wait_ready(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
        if (!ok) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_frame(logic [15:0] f);
        bit ok;
        int start;
        wait_ready(ok);
        if (!ok) return;
        data  = 1'b1;
        start = cyc;
        sb_q.push_back(predict(f, start));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("busy_in_shift", 32'(busy), 32'd1);
            data = f[i];
        end
        @(negedge clk);            // CHECK: data is don't-care
        chk("busy_in_check", 32'(busy), 32'd1);
        data = 1'($urandom);
        @(negedge clk);            // HOLD: data is don't-care
        chk("busy_in_hold", 32'(busy), 32'd1);
        data = 1'($urandom);
        @(negedge clk);
        chk("busy_after_hold", 32'(busy), 32'd0);
        data = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end expected end");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit ok;
        model_reset();
        for (int i = 0; i < 16; i++) tx_seq[i] = 8'd0;
        reset  = 1'b1;
        data   = 1'b0;
        reset2 = 1'b1;
        data2  = 1'b0;
        repeat (3) @(negedge clk);
        data = 1'b1;               // start bit coincident with reset: ignored
        @(negedge clk);
        reset  = 1'b0;
        reset2 = 1'b0;
        data   = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flit_valid", 32'(flit_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_flit", 32'(flit), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        chk("rst_busy_after", 32'(busy), 32'd0);

        // directed: good flit, dest error, sequence run from src 1
        send_frame(16'h0315);
        send_frame(16'h0316);
        send_frame(16'h0415);
        send_frame(16'h0615);
        send_frame(16'h0715);

        // randomized traffic, mostly in-sequence, some dest/seq faults
        for (int k = 0; k < 40; k++) begin
            logic [3:0] s, d;
            logic [7:0] q;
            s = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(ID);
            if ($urandom_range(0, 4) == 0) tx_seq[s] = 8'($urandom);
            q = tx_seq[s];
            tx_seq[s] = q + 8'd1;
            send_frame({q, s, d});
        end

        // reset in the middle of SHIFT (after bit 7)
        wait_ready(ok);
        data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data = 1'($urandom);
        end
        @(negedge clk);
        reset = 1'b1;
        data  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        data  = 1'b0;
        model_reset();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_flit_valid", 32'(flit_valid), 32'd0);
        chk("midrst_rx_count", 32'(rx_count), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        repeat (20) @(negedge clk);
        send_frame(16'h1255);
        send_frame(16'h2315);

        // saturation: preload counters near the top
        dut.rx_count_q  = 16'hFFFE;
        dut.err_count_q = 16'hFFFF;
        m_rx = 65534;
        m_ec = 65535;
        send_frame(16'h3355);
        send_frame(16'h3455);
        send_frame(16'h0010);      // dest 0: error while err_count saturated
        chk("sat_rx_count", 32'(rx_count), 32'hFFFF);
        chk("sat_err_count", 32'(err_count), 32'hFFFF);

        // HOSP=0: blind back-to-back frames; sink must stick in HOLD
        for (int k = 0; k < 20; k++) begin
            data2 = 1'b1;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                data2 = (k == 0) ? 1'(16'h0315 >> i) : 1'($urandom);
            end
            @(negedge clk);
        end
        data2 = 1'b0;
        repeat (10) @(negedge clk);
        chk("h0_pulses", 32'(h0_pulses), 32'd1);
        chk("h0_rx_count", 32'(rx_count2), 32'd1);
        chk("h0_flit", 32'(flit2), 32'h0315);
        chk("h0_err_count", 32'(err_count2), 32'd0);
        chk("h0_busy", 32'(busy2), 32'd1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_checking_sink.md
SERIAL_CHECKING_SINK -- requirements
Module: serial_checking_sink

Interface
REQ-001 SHALL have parameter ID, default 0: the node address of the attached router port.
REQ-002 SHALL have parameter FLIT_W, default 16: the flit width in bits.
REQ-003 SHALL have parameter ADDR_SZ, default 4: the width of the address field.
REQ-004 SHALL have parameter HOSP, default 255: hospitality, 0-255; 255 means never throttle.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port busy, output, 1 bit: flow control to the router's local tx; 1 means the sink is not ready for a new frame.
REQ-008 SHALL have port data, input, 1 bit: the serial line from the router's local tx; it idles at 0.
REQ-009 SHALL have port flit_valid, output, 1 bit: one-cycle pulse meaning a flit has been received.
REQ-010 SHALL have port flit, output, FLIT_W bits: the last received flit, held until the next one arrives.
REQ-011 SHALL have port rx_count, output, 16 bits: count of flits received.
REQ-012 SHALL have port err_count, output, 16 bits: count of flits with a detected error.
REQ-013 SHALL have port err, output, 1 bit: pulse coincident with flit_valid when the flit is in error.

Function
REQ-014 SHALL use this frame format: one start bit (1), then FLIT_W data bits, LSB first, one bit per cycle.
REQ-015 SHALL use this flit field layout: dest = flit[ADDR_SZ-1:0]; src = flit[2*ADDR_SZ-1:ADDR_SZ]; seq = flit[FLIT_W-1:2*ADDR_SZ] (SEQ_W bits).
REQ-016 SHALL implement the FSM states IDLE, SHIFT, CHECK and HOLD.
REQ-017 SHALL, in IDLE, drive busy=0; data=1 sampled -> SHIFT, with the bit counter cleared and busy=1 from the next cycle.
REQ-018 SHALL, in SHIFT, shift data into bit position counter each cycle; after FLIT_W samples -> CHECK. busy=1 throughout SHIFT.
REQ-019 SHALL, in CHECK, hold for one cycle: flit_valid=1, flit=assembled word, counters updated, err set if in error; then -> HOLD.
REQ-020 SHALL, in HOLD, keep busy=1 until lfsr <= HOSP is sampled, then -> IDLE; with HOSP=255, HOLD lasts exactly 1 cycle.
REQ-021 SHALL produce flit_valid exactly FLIT_W+1 cycles after the cycle in which the start bit was sampled.
REQ-022 SHALL treat data as don't-care in CHECK and HOLD, and ignore it there.
REQ-023 SHALL define lfsr as an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advancing every non-reset cycle, seeded {ID[6:0],1'b1}.
REQ-024 SHALL flag a destination error when dest != ID[ADDR_SZ-1:0].
REQ-025 SHALL increment rx_count on every flit_valid and err_count on every err; both counters saturate at 16'hFFFF.
REQ-026 SHALL count an erroneous flit in both rx_count and err_count.

Reset
REQ-027 SHALL, on reset, set state=IDLE, busy=0, flit_valid=0, err=0, flit=0, rx_count=0, err_count=0, lfsr=seed, and clear all sequence-table valid bits.
REQ-028 SHALL, on reset asserted mid-frame (SHIFT/CHECK/HOLD), discard the partial flit without asserting flit_valid or updating the counters.
REQ-029 SHALL ignore a data=1 sampled in the same cycle as reset.

Configuration
REQ-030 SHALL provide sequence checking under the macro SINK_SEQ_CHECK_EN.
REQ-031 SHALL, with SINK_SEQ_CHECK_EN defined, keep per-src tables: valid[2^ADDR_SZ] and expected[2^ADDR_SZ][SEQ_W].
REQ-032 SHALL, with SINK_SEQ_CHECK_EN defined, accept any seq on the first flit from a src (valid=0) and set valid=1.
REQ-033 SHALL, with SINK_SEQ_CHECK_EN defined, flag a sequence error when valid=1 and seq != expected[src].
REQ-034 SHALL, with SINK_SEQ_CHECK_EN defined, always load expected[src] = seq+1 mod 2^SEQ_W, including after a sequence error (resynchronise).
REQ-035 SHALL, with SINK_SEQ_CHECK_EN defined, set err = dest error OR sequence error, and increment err_count once per flit.
REQ-036 SHALL, with SINK_SEQ_CHECK_EN undefined, omit the tables entirely and set err = dest error only.

Verification
REQ-037 SHALL cover: ID=5, HOSP=255; send flit 16'h0315 (seq 3, src 1, dest 5) -> flit_valid at start+17, flit=16'h0315, rx_count=1, err=0, busy low 2 cycles after flit_valid.
REQ-038 SHALL cover: ID=5; send flit 16'h0316 (dest 6) -> err=1 with flit_valid, err_count=1, rx_count=1.
REQ-039 SHALL cover: SINK_SEQ_CHECK_EN defined, ID=5; send seq 3, 4, 6 from src 1 -> err only on the third flit, err_count=1; a following seq 7 -> no error.
REQ-040 SHALL cover: reset pulsed at SHIFT bit 7 -> no flit_valid, counters 0, busy=0 the next cycle; a following full frame is received correctly.
REQ-041 SHALL cover: HOSP=0, 20 back-to-back frames -> busy held in HOLD until lfsr=0 is impossible (the LFSR is never 0), so exactly 1 flit is received and busy stays high.
REQ-042 SHALL cover: rx_count preloaded via 65536 frames (or a forced value of 16'hFFFF) plus one more frame -> rx_count stays 16'hFFFF.
